// File: rtl/counter_pkg.sv
// Shared helpers for the saturating cycle counter.
// Parameter legality is checked here so the counter can assert on it during elaboration.
package counter_pkg;

    // True when max_val fits in an unsigned field of the given width.
    function automatic bit cnt_max_legal(int unsigned width, longint unsigned max_val);
        if (width >= 64) begin
            return 1'b1;
        end
        return max_val <= ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/counter.sv
// Free-running saturating up-counter: counts cycles since the last synchronous clear,
// holding at count_max until cleared. Output is purely registered.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned     count_width = 8,
    parameter longint unsigned count_max   = (64'd1 << count_width) - 64'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [count_width-1:0] count
);

    if (count_width < 1) begin : g_bad_width
        $fatal(1, "counter: count_width must be at least 1");
    end

    if (!cnt_max_legal(count_width, count_max)) begin : g_bad_max
        $fatal(1, "counter: count_max does not fit in count_width bits");
    end

    localparam logic [count_width-1:0] MAX = count_width'(count_max);
    localparam logic [count_width-1:0] ONE = count_width'(1);

    // Power-up value of 0 so counting starts correctly even if reset is never asserted.
    logic [count_width-1:0] r_count = '0;
    logic                   w_sat;

    assign w_sat = (r_count == MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (!w_sat) begin
            r_count <= r_count + ONE;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_counter.sv
// Directed-vector bench for the saturating counter across several parameterisations.
module tb_counter;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_c = 1'b0;
    logic [3:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic [12:0] cnt_c;
    logic [3:0]  cnt_z;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    counter #(.count_width(4),  .count_max(10))   u_a (.clk(clk), .reset(rst_a), .count(cnt_a));
    counter #(.count_width(3),  .count_max(7))    u_b (.clk(clk), .reset(1'b0),  .count(cnt_b));
    counter #(.count_width(13), .count_max(5000)) u_c (.clk(clk), .reset(rst_c), .count(cnt_c));
    counter #(.count_width(4),  .count_max(0))    u_z (.clk(clk), .reset(rst_a), .count(cnt_z));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_a;
        int unsigned exp_b;
        int unsigned exp_c;

        // Power-up value before any clock edge
        #1;
        check("powerup_a", 32'(cnt_a), 0);
        check("powerup_b", 32'(cnt_b), 0);
        check("powerup_c", 32'(cnt_c), 0);
        check("powerup_z", 32'(cnt_z), 0);

        // Free count from time 0, reset never asserted: count = min(k, max) after edge k
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_a = (k < 10) ? k : 10;
            exp_b = (k < 7)  ? k : 7;
            check("count_a", 32'(cnt_a), exp_a);
            check("count_b", 32'(cnt_b), exp_b);
            check("count_c", 32'(cnt_c), k);
            check("count_z", 32'(cnt_z), 0);
        end

        // Clear while saturated at 10
        rst_a = 1'b1;
        @(negedge clk);
        check("clr_sat", 32'(cnt_a), 0);
        check("clr_sat_z", 32'(cnt_z), 0);
        rst_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("restart", 32'(cnt_a), k);
        end

        // Clear mid-count at 6
        rst_a = 1'b1;
        @(negedge clk);
        check("clr_mid", 32'(cnt_a), 0);
        rst_a = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("resume", 32'(cnt_a), k);
        end

        // Clear held for four cycles
        rst_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("held_clr", 32'(cnt_a), 0);
            check("held_clr_z", 32'(cnt_z), 0);
        end
        rst_a = 1'b0;
        @(negedge clk);
        check("after_held", 32'(cnt_a), 1);
        check("after_held_z", 32'(cnt_z), 0);

        // Full-range instance stays at 7 with no wrap
        check("no_wrap_b", 32'(cnt_b), 7);

        // Large timer: clear, then run uninterrupted past saturation
        rst_c = 1'b1;
        @(negedge clk);
        check("clr_c", 32'(cnt_c), 0);
        rst_c = 1'b0;
        for (int n = 1; n <= 5003; n++) begin
            @(negedge clk);
            exp_c = (n < 5000) ? n : 5000;
            if (n == 1 || n == 4998 || n == 4999 || n >= 5000) begin
                check("large_c", 32'(cnt_c), exp_c);
            end
        end
        check("end_z", 32'(cnt_z), 0);
        check("end_b", 32'(cnt_b), 7);
        check("end_a", 32'(cnt_a), 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
